pulse_peak_detector: RTL and testbench
======================================

# pulse_peak_detector

Consumer-side counterpart of the exponential signal generator and filter chain. It takes the filter output stream, detects pulses by threshold crossing, and measures each pulse's peak amplitude, peak timestamp and width. It flags pile-up, where the generator's overlay produces multiple maxima in one pulse. Each finished measurement is handed to downstream readout through a single-entry valid/ready output register.

## Interface
- DATA_W, default 19: width of signed filter sample (SIZE_FILTER_DATA+3).
- TIME_W, default 16: width of free-running timestamp counter.
- MAX_LEN, default 64: maximum pulse width in samples before forced termination; range 1..255.
- HOLDOFF, default 8: cycles ignored after a pulse ends; 0 allowed.
- clk, in, 1: single clock; one sample per cycle.
- reset, in, 1: synchronous, active-high.
- input_data, in, DATA_W: signed filter sample.
- threshold, in, DATA_W: signed detection threshold; quasi-static.
- out_ready, in, 1: downstream accepts the event.
- out_valid, out, 1: event available.
- out_amplitude, out, DATA_W: signed peak value.
- out_time, out, TIME_W: timestamp of the first sample equal to the peak.
- out_width, out, 8: number of samples above threshold.
- out_pileup, out, 1: more than one local maximum, or forced termination.
- drop_count, out, 8: events lost on a full output register; saturates at 255.

## Operation
- Timestamp counter ts: 0 after reset, +1 every cycle, wraps modulo 2^TIME_W. A sample taken at an edge is stamped with the ts value at that edge.
- Compare rule: "above" means input_data > threshold, signed and strictly greater.
- FSM states: IDLE, ABOVE, WAIT_LOW, HOLD.
- IDLE: on an above sample, go to ABOVE. Set peak=sample, peak_t=ts, width=1, falling=0, pileup=0, prev=sample.
- ABOVE, above sample:
  - width+1.
  - If sample > peak, load peak and peak_t. Equal samples do not update.
  - If sample < prev, set falling=1.
  - If falling=1 and sample > prev, set pileup=1 and clear falling.
  - prev=sample.
- ABOVE, sample not above: emit the event; go to HOLD if HOLDOFF>0, else IDLE. The below sample is not counted in width.
- ABOVE with width==MAX_LEN and the current sample still above: emit with out_pileup=1 and out_width=MAX_LEN; go to WAIT_LOW.
- WAIT_LOW: remain until a sample is not above, then go to HOLD or IDLE as above.
- HOLD: count HOLDOFF cycles with input ignored, then go to IDLE. Detection resumes on the first IDLE cycle.
- Emit rules:
  - If the output register is empty, or is being transferred on this same edge (out_valid & out_ready), load the output fields and keep or set out_valid=1.
  - Otherwise discard the event and increment drop_count, saturating.
- Transfer: out_valid clears on an edge with out_valid & out_ready unless a new event loads on that same edge.
- Output fields are stable while out_valid=1 and out_ready=0.

## Timing
- Reset values:
  - out_valid=0; out_amplitude, out_time, out_width, out_pileup = 0; drop_count=0.
  - ts=0; state=IDLE.
  - All internal registers are 0.
- Reset mid-pulse or mid-HOLD discards the partial event. Reset has priority over every other action.
- Latency: when the terminating sample (first not-above sample, or the MAX_LEN-th above sample) is presented at edge n, out_valid=1 is visible after edge n.
- Minimum event spacing: width + 1 + HOLDOFF cycles.
- Back-to-back emit with out_ready=1 held is lossless.
- Timestamp wrap: no special handling; downstream computes differences modulo 2^TIME_W.
- Threshold changes take effect on the next compare. Changing the threshold mid-pulse is not defined for measurement accuracy but must not hang the FSM.

## Test plan
- Single pulse: threshold=100; samples 0,150,300,250,120,50 starting at ts=10; out_ready=1. Required: one event with amplitude=300, time=12, width=4, pileup=0, and out_valid high for exactly 1 cycle.
- Pile-up: threshold=100; samples 200,400,300,350,150,0. Required: amplitude=400, width=5, pileup=1.
- Forced termination: MAX_LEN=64; input held at 500 for 100 cycles, threshold=100. Required: one event with width=64 and pileup=1, and no second event until the input drops and HOLDOFF expires.
- Backpressure: out_ready=0 for three consecutive pulses with HOLDOFF=8. Required: the first event is held stable, drop_count=2, and out_ready=1 then transfers the first event with no others.
- Equal peaks and HOLDOFF: samples 150,300,300,90, then a new crossing 2 cycles later. Required: time points to the first 300; the second crossing is ignored; a crossing at 9 cycles after the end is detected.
- Reset mid-pulse and timestamp wrap: assert reset during ABOVE. Required: no event and all outputs 0. Then run to ts=65535 and place a pulse peak there with TIME_W=16. Required: out_time=65535, and the next pulse is stamped with wrapped values starting at 0.

Source files
------------

// File: rtl/pulse_peak_detector.sv
// pulse_peak_detector
// Watches the filtered sample stream for threshold crossings and measures each
// pulse: peak amplitude, timestamp of the first peak sample, width above
// threshold, and a pile-up flag for multiple maxima or over-long pulses.
// Finished measurements sit in a single-entry valid/ready output register;
// events that arrive while it is full are counted in drop_count.
module pulse_peak_detector #(
    parameter int DATA_W  = 19,
    parameter int TIME_W  = 16,
    parameter int MAX_LEN = 64,
    parameter int HOLDOFF = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] input_data,
    input  logic signed [DATA_W-1:0] threshold,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_amplitude,
    output logic [TIME_W-1:0]        out_time,
    output logic [7:0]               out_width,
    output logic                     out_pileup,
    output logic [7:0]               drop_count
);

    localparam int HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
    localparam logic [7:0] MAX_WIDTH = 8'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, ABOVE, WAIT_LOW, HOLD} state_t;

    // With no holdoff configured the detector re-arms straight away.
    localparam state_t AFTER_PULSE = (HOLDOFF > 0) ? HOLD : IDLE;

    state_t                    state_q, state_d;
    logic [TIME_W-1:0]         ts_q, ts_d;
    logic signed [DATA_W-1:0]  peak_q, peak_d;
    logic [TIME_W-1:0]         peak_t_q, peak_t_d;
    logic [7:0]                width_q, width_d;
    logic                      falling_q, falling_d;
    logic                      pileup_q, pileup_d;
    logic signed [DATA_W-1:0]  prev_q, prev_d;
    logic [HOLD_W-1:0]         hold_cnt_q, hold_cnt_d;

    logic                      out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0]  out_amplitude_q, out_amplitude_d;
    logic [TIME_W-1:0]         out_time_q, out_time_d;
    logic [7:0]                out_width_q, out_width_d;
    logic                      out_pileup_q, out_pileup_d;
    logic [7:0]                drop_count_q, drop_count_d;

    logic                      above;
    logic                      emit;
    logic                      load;
    logic signed [DATA_W-1:0]  ev_amp;
    logic [TIME_W-1:0]         ev_time;
    logic [7:0]                ev_width;
    logic                      ev_pileup;

    assign above = input_data > threshold;

    // Pulse measurement FSM: tracks peak/shape and decides when an event is emitted.
    always_comb begin
        state_d    = state_q;
        ts_d       = ts_q + 1'b1;
        peak_d     = peak_q;
        peak_t_d   = peak_t_q;
        width_d    = width_q;
        falling_d  = falling_q;
        pileup_d   = pileup_q;
        prev_d     = prev_q;
        hold_cnt_d = hold_cnt_q;
        emit       = 1'b0;
        ev_amp     = peak_q;
        ev_time    = peak_t_q;
        ev_width   = width_q;
        ev_pileup  = pileup_q;

        case (state_q)
            IDLE: begin
                if (above) begin
                    peak_d    = input_data;
                    peak_t_d  = ts_q;
                    width_d   = 8'd1;
                    falling_d = 1'b0;
                    pileup_d  = 1'b0;
                    prev_d    = input_data;
                    if (MAX_WIDTH == 8'd1) begin
                        emit      = 1'b1;
                        ev_amp    = input_data;
                        ev_time   = ts_q;
                        ev_width  = MAX_WIDTH;
                        ev_pileup = 1'b1;
                        state_d   = WAIT_LOW;
                    end else begin
                        state_d = ABOVE;
                    end
                end
            end
            ABOVE: begin
                if (above) begin
                    width_d = width_q + 8'd1;
                    if (input_data > peak_q) begin
                        peak_d   = input_data;
                        peak_t_d = ts_q;
                    end
                    if (input_data < prev_q) begin
                        falling_d = 1'b1;
                    end else if (falling_q && (input_data > prev_q)) begin
                        pileup_d  = 1'b1;
                        falling_d = 1'b0;
                    end
                    prev_d = input_data;
                    if (width_d == MAX_WIDTH) begin
                        emit      = 1'b1;
                        ev_amp    = peak_d;
                        ev_time   = peak_t_d;
                        ev_width  = MAX_WIDTH;
                        ev_pileup = 1'b1;
                        state_d   = WAIT_LOW;
                    end
                end else begin
                    emit       = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = AFTER_PULSE;
                end
            end
            WAIT_LOW: begin
                if (!above) begin
                    hold_cnt_d = '0;
                    state_d    = AFTER_PULSE;
                end
            end
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output register: load on emit when free or draining this edge, otherwise count a drop.
    always_comb begin
        load            = emit && (!out_valid_q || out_ready);
        out_valid_d     = out_valid_q;
        out_amplitude_d = out_amplitude_q;
        out_time_d      = out_time_q;
        out_width_d     = out_width_q;
        out_pileup_d    = out_pileup_q;
        drop_count_d    = drop_count_q;

        if (load) begin
            out_valid_d     = 1'b1;
            out_amplitude_d = ev_amp;
            out_time_d      = ev_time;
            out_width_d     = ev_width;
            out_pileup_d    = ev_pileup;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (emit && (drop_count_q != 8'hFF)) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end
    end

    // State and output registers; reset clears everything and discards any partial pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            ts_q            <= '0;
            peak_q          <= '0;
            peak_t_q        <= '0;
            width_q         <= '0;
            falling_q       <= 1'b0;
            pileup_q        <= 1'b0;
            prev_q          <= '0;
            hold_cnt_q      <= '0;
            out_valid_q     <= 1'b0;
            out_amplitude_q <= '0;
            out_time_q      <= '0;
            out_width_q     <= '0;
            out_pileup_q    <= 1'b0;
            drop_count_q    <= '0;
        end else begin
            state_q         <= state_d;
            ts_q            <= ts_d;
            peak_q          <= peak_d;
            peak_t_q        <= peak_t_d;
            width_q         <= width_d;
            falling_q       <= falling_d;
            pileup_q        <= pileup_d;
            prev_q          <= prev_d;
            hold_cnt_q      <= hold_cnt_d;
            out_valid_q     <= out_valid_d;
            out_amplitude_q <= out_amplitude_d;
            out_time_q      <= out_time_d;
            out_width_q     <= out_width_d;
            out_pileup_q    <= out_pileup_d;
            drop_count_q    <= drop_count_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_amplitude = out_amplitude_q;
    assign out_time      = out_time_q;
    assign out_width     = out_width_q;
    assign out_pileup    = out_pileup_q;
    assign drop_count    = drop_count_q;

endmodule

// File: tb/tb_pulse_peak_detector.sv
// tb_pulse_peak_detector
// Directed stimulus for pulse_peak_detector. Expected events are queued as the
// pulses are driven and compared whenever the DUT hands an event downstream.
module tb_pulse_peak_detector;

    localparam int DATA_W  = 19;
    localparam int TIME_W  = 16;
    localparam int MAX_LEN = 64;
    localparam int HOLDOFF = 8;

    logic                     clk = 1'b0;
    logic                     reset;
    logic signed [DATA_W-1:0] input_data;
    logic signed [DATA_W-1:0] threshold;
    logic                     out_ready;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_amplitude;
    logic [TIME_W-1:0]        out_time;
    logic [7:0]               out_width;
    logic                     out_pileup;
    logic [7:0]               drop_count;

    typedef struct {
        logic signed [DATA_W-1:0] amp;
        logic [TIME_W-1:0]        t;
        logic [7:0]               width;
        logic                     pileup;
    } event_t;

    event_t            exp_q[$];
    event_t            mon_ev;
    int                vectors     = 0;
    int                miscompares = 0;
    logic [TIME_W-1:0] tb_ts;
    logic [TIME_W-1:0] stamp;
    logic [TIME_W-1:0] t0;

    pulse_peak_detector #(
        .DATA_W (DATA_W),
        .TIME_W (TIME_W),
        .MAX_LEN(MAX_LEN),
        .HOLDOFF(HOLDOFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .input_data   (input_data),
        .threshold    (threshold),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_amplitude(out_amplitude),
        .out_time     (out_time),
        .out_width    (out_width),
        .out_pileup   (out_pileup),
        .drop_count   (drop_count)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic push_event(input logic signed [DATA_W-1:0] amp, input logic [TIME_W-1:0] t,
                              input logic [7:0] width, input logic pileup);
        event_t ev;
        ev.amp    = amp;
        ev.t      = t;
        ev.width  = width;
        ev.pileup = pileup;
        exp_q.push_back(ev);
    endtask

    // Present one sample for one edge; stamp records the timestamp it should carry.
    task automatic apply_stimulus(input logic signed [DATA_W-1:0] sample);
        input_data = sample;
        stamp      = tb_ts;
        @(posedge clk);
        #1;
        tb_ts = tb_ts + 1'b1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        input_data = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        tb_ts = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check_output({tag, "_valid"}, out_valid, 0);
        check_output({tag, "_amplitude"}, out_amplitude, 0);
        check_output({tag, "_time"}, out_time, 0);
        check_output({tag, "_width"}, out_width, 0);
        check_output({tag, "_pileup"}, out_pileup, 0);
        check_output({tag, "_drop_count"}, drop_count, 0);
    endtask

    // Scoreboard: every transfer downstream must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            check_output("event_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                mon_ev = exp_q.pop_front();
                check_output("amplitude", out_amplitude, mon_ev.amp);
                check_output("time", out_time, mon_ev.t);
                check_output("width", out_width, mon_ev.width);
                check_output("pileup", out_pileup, mon_ev.pileup);
            end
        end
    end

    // Guard against a stuck simulation.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence.
    initial begin
        reset      = 1'b1;
        threshold  = 19'sd100;
        out_ready  = 1'b1;
        input_data = '0;
        tb_ts      = '0;
        do_reset();
        check_reset_state("reset");

        // Single pulse starting at ts=10
        while (tb_ts != 16'd10) apply_stimulus(19'sd0);
        push_event(19'sd300, 16'd12, 8'd4, 1'b0);
        apply_stimulus(19'sd0);
        apply_stimulus(19'sd150);
        apply_stimulus(19'sd300);
        apply_stimulus(19'sd250);
        apply_stimulus(19'sd120);
        check_output("single_valid_before", out_valid, 0);
        apply_stimulus(19'sd50);
        check_output("single_valid_latency", out_valid, 1);
        apply_stimulus(19'sd0);
        check_output("single_valid_one_cycle", out_valid, 0);
        repeat (10) apply_stimulus(19'sd0);

        // Pile-up: second local maximum
        t0 = tb_ts;
        push_event(19'sd400, t0 + 16'd1, 8'd5, 1'b1);
        apply_stimulus(19'sd200);
        apply_stimulus(19'sd400);
        apply_stimulus(19'sd300);
        apply_stimulus(19'sd350);
        apply_stimulus(19'sd150);
        apply_stimulus(19'sd0);
        repeat (10) apply_stimulus(19'sd0);

        // Forced termination at MAX_LEN
        t0 = tb_ts;
        push_event(19'sd500, t0, 8'(MAX_LEN), 1'b1);
        for (int i = 0; i < 100; i++) begin
            apply_stimulus(19'sd500);
            if (i == MAX_LEN - 2) check_output("forced_valid_before", out_valid, 0);
            if (i == MAX_LEN - 1) check_output("forced_valid_at_max", out_valid, 1);
        end
        apply_stimulus(19'sd0);
        repeat (10) apply_stimulus(19'sd0);
        check_output("forced_drop_count", drop_count, 0);

        // Backpressure: three pulses with the output register blocked
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(19'sd150);
            apply_stimulus(19'sd250 + 19'(10 * k));
            if (k == 0) push_event(19'sd250, stamp, 8'd2, 1'b0);
            apply_stimulus(19'sd0);
            repeat (HOLDOFF) apply_stimulus(19'sd0);
        end
        check_output("bp_valid_held", out_valid, 1);
        check_output("bp_amplitude_held", out_amplitude, 250);
        check_output("bp_width_held", out_width, 2);
        check_output("bp_drop_count", drop_count, 2);
        out_ready = 1'b1;
        apply_stimulus(19'sd0);
        check_output("bp_valid_drained", out_valid, 0);
        repeat (5) apply_stimulus(19'sd0);

        // Equal peaks and holdoff boundary
        t0 = tb_ts;
        push_event(19'sd300, t0 + 16'd1, 8'd3, 1'b0);
        apply_stimulus(19'sd150);
        apply_stimulus(19'sd300);
        apply_stimulus(19'sd300);
        apply_stimulus(19'sd90);
        apply_stimulus(19'sd0);
        apply_stimulus(19'sd200);
        repeat (5) apply_stimulus(19'sd0);
        apply_stimulus(19'sd250);
        apply_stimulus(19'sd200);
        push_event(19'sd200, stamp, 8'd1, 1'b0);
        apply_stimulus(19'sd0);
        check_output("holdoff_event_valid", out_valid, 1);
        repeat (10) apply_stimulus(19'sd0);

        // Reset mid-pulse discards the partial event
        apply_stimulus(19'sd150);
        apply_stimulus(19'sd300);
        do_reset();
        check_reset_state("mid_reset");

        // Timestamp wrap: peak placed at ts=65535
        while (tb_ts != 16'd65533) apply_stimulus(19'sd0);
        apply_stimulus(19'sd150);
        apply_stimulus(19'sd200);
        apply_stimulus(19'sd300);
        apply_stimulus(19'sd250);
        push_event(19'sd300, 16'd65535, 8'd4, 1'b0);
        apply_stimulus(19'sd0);
        check_output("wrap_time_direct", out_time, 65535);
        while (tb_ts != 16'd10) apply_stimulus(19'sd0);
        push_event(19'sd400, 16'd10, 8'd1, 1'b0);
        apply_stimulus(19'sd400);
        apply_stimulus(19'sd0);
        repeat (5) apply_stimulus(19'sd0);

        check_output("pending_events", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
